rect_overlay_wr: RTL and testbench

- Parametrised rectangle-overlay DDR writer. Multi-entry request queue; draws rectangle outlines of configurable thickness in a configurable colour into a frame buffer through the shared DDR write-burst port.
- Sits between tracking logic (requests already synchronised into mem_clk) and the memory-controller write arbiter.
- Splits long segments into MAX_BURST-sized bursts and reports per-rectangle completion.

---
 rtl/rect_overlay_pkg.sv | 43 ++++
 rtl/rect_overlay_if.sv | 23 ++
 rtl/rect_req_fifo.sv | 48 ++++
 rtl/rect_overlay_wr.sv | 211 +++++++++++++++++++++
 tb/tb_rect_overlay_wr.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rect_overlay_pkg.sv
// Shared types and helpers for the rectangle-overlay DDR writer.
// Frame geometry and bus width live here so the queue entry struct can be shared by every file.
package rect_overlay_pkg;

   localparam int unsigned X_W            = 11;
   localparam int unsigned Y_W            = 11;
   localparam int unsigned FRAME_W        = 2;
   localparam int unsigned DATA_W         = 64;
   localparam int unsigned PIX_PER_WORD   = DATA_W / 16;
   localparam int unsigned BYTES_PER_WORD = DATA_W / 8;
   localparam int unsigned PACK_W         = FRAME_W + Y_W + X_W + 1;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSeg,
      StReq,
      StWait,
      StDone
   } state_e;

   typedef struct packed {
      logic [FRAME_W-1:0] frame;
      logic [X_W-1:0]     x1;
      logic [X_W-1:0]     x2;
      logic [Y_W-1:0]     y1;
      logic [Y_W-1:0]     y2;
      logic [15:0]        colour;
`ifdef RECT_FILL_EN
      logic               fill;
`endif
   } rect_req_t;

   // Byte address of a word: {frame, line, first pixel of word, 1'b0}.
   function automatic logic [PACK_W-1:0] pack_addr(logic [FRAME_W-1:0] frame,
                                                   logic [Y_W-1:0] line,
                                                   logic [X_W-1:0] word);
      logic [X_W-1:0] px;
      px = X_W'(word * PIX_PER_WORD);
      return {frame, line, px, 1'b0};
   endfunction

endpackage

// File: rtl/rect_overlay_if.sv
// Write-burst port between the overlay writer (master) and the memory-controller arbiter.
interface rect_overlay_if
   import rect_overlay_pkg::*;
#(
   parameter int unsigned ADDR_W = 27
);
   logic              wr_burst_req;
   logic [ADDR_W-1:0] wr_burst_addr;
   logic [9:0]        wr_burst_len;
   logic [DATA_W-1:0] wr_burst_data;
   logic              wr_burst_data_req;
   logic              burst_finish;

   modport master (
      output wr_burst_req, wr_burst_addr, wr_burst_len, wr_burst_data,
      input  wr_burst_data_req, burst_finish
   );

   modport slave (
      input  wr_burst_req, wr_burst_addr, wr_burst_len, wr_burst_data,
      output wr_burst_data_req, burst_finish
   );
endinterface

// File: rtl/rect_req_fifo.sv
// Synchronous request queue (power-of-2 depth) with full/empty and a flush input.
module rect_req_fifo
   import rect_overlay_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      mem_clk,
   input  logic      rst_n,
   input  logic      flush,
   input  logic      push,
   input  rect_req_t wdata,
   input  logic      pop,
   output rect_req_t rdata,
   output logic      full,
   output logic      empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   rect_req_t     mem_q [DEPTH];
   logic [AW:0]   wptr_q, rptr_q;
   logic [AW-1:0] widx;
   logic          do_push, do_pop;

   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign rdata   = mem_q[rptr_q[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // A push coinciding with a flush survives as the sole entry.
   assign widx    = flush ? '0 : wptr_q[AW-1:0];

   always_ff @(posedge mem_clk) begin
      if (do_push) mem_q[widx] <= wdata;
   end

   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else if (flush) begin
         rptr_q <= '0;
         wptr_q <= do_push ? (AW+1)'(1) : '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
         if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
      end
   end
endmodule

// File: rtl/rect_overlay_wr.sv
// Rectangle-overlay DDR writer: queues requests and draws outlines as word-aligned write bursts.
// Optional interior fill is enabled with the RECT_FILL_EN macro.
module rect_overlay_wr
   import rect_overlay_pkg::*;
#(
   parameter int unsigned ADDR_W    = 27,
   parameter int unsigned MAX_BURST = 128,
   parameter int unsigned THICK     = 1,
   parameter int unsigned Q_DEPTH   = 4
) (
   input  logic               mem_clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [FRAME_W-1:0] req_frame,
   input  logic [X_W-1:0]     req_x1,
   input  logic [X_W-1:0]     req_x2,
   input  logic [Y_W-1:0]     req_y1,
   input  logic [Y_W-1:0]     req_y2,
   input  logic [15:0]        req_colour,
   input  logic               req_fill,
   input  logic               abort,
   rect_overlay_if.master     wr,
   output logic               rect_done,
   output logic               rect_err,
   output logic               busy
);
   localparam logic [Y_W:0] THICK_L = (Y_W+1)'(THICK);
   localparam logic [X_W:0] MAX_L   = (X_W+1)'(MAX_BURST);

   state_e            state_q, state_d;
   rect_req_t         ent_q, ent_d, req_ent, head;
   logic [Y_W:0]      line_q, line_d;
   logic              seg_q, seg_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [X_W:0]      remain_q, remain_d, burst_len, seg_cnt;
   logic              abort_pend_q, abort_pend_d;
   logic              done_q, done_d, err_q, err_d;
   logic [DATA_W-1:0] data_q;
   logic              push, pop, flush, full, empty, fill, full_span;
   logic [X_W-1:0]    ws, we, seg_start;
   logic [Y_W:0]      dy_top, dy_bot;

   always_comb begin
      req_ent        = '0;
      req_ent.frame  = req_frame;
      req_ent.x1     = req_x1;
      req_ent.x2     = req_x2;
      req_ent.y1     = req_y1;
      req_ent.y2     = req_y2;
      req_ent.colour = req_colour;
`ifdef RECT_FILL_EN
      req_ent.fill   = req_fill;
`endif
   end

`ifdef RECT_FILL_EN
   assign fill = ent_q.fill;
`else
   logic unused_fill;
   assign unused_fill = req_fill;
   assign fill        = 1'b0;
`endif

   assign req_ready = !full;
   assign push      = req_valid && !full && !abort;

   rect_req_fifo #(
      .DEPTH (Q_DEPTH)
   ) u_fifo (
      .mem_clk (mem_clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .push    (push),
      .wdata   (req_ent),
      .pop     (pop),
      .rdata   (head),
      .full    (full),
      .empty   (empty)
   );

   assign ws        = X_W'(ent_q.x1 / PIX_PER_WORD);
   assign we        = X_W'(ent_q.x2 / PIX_PER_WORD);
   assign dy_top    = line_q - {1'b0, ent_q.y1};
   assign dy_bot    = {1'b0, ent_q.y2} - line_q;
   assign full_span = (dy_top < THICK_L) || (dy_bot < THICK_L) || fill;
   assign seg_start = (full_span || !seg_q) ? ws : we;
   assign seg_cnt   = full_span ? ({1'b0, we - ws} + (X_W+1)'(1)) : (X_W+1)'(1);
   assign burst_len = (remain_q > MAX_L) ? MAX_L : remain_q;

   always_comb begin
      state_d      = state_q;
      ent_d        = ent_q;
      line_d       = line_q;
      seg_d        = seg_q;
      addr_d       = addr_q;
      remain_d     = remain_q;
      abort_pend_d = abort_pend_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      pop          = 1'b0;
      flush        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (abort) begin
               flush = 1'b1;
            end else if (!empty) begin
               pop     = 1'b1;
               ent_d   = head;
               state_d = StLoad;
            end
         end
         StLoad: begin
            if (abort) begin
               flush   = 1'b1;
               done_d  = 1'b1;
               state_d = StIdle;
            end else if ((ent_q.x2 < ent_q.x1) || (ent_q.y2 < ent_q.y1)) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               line_d  = {1'b0, ent_q.y1};
               seg_d   = 1'b0;
               state_d = StSeg;
            end
         end
         StSeg: begin
            if (abort) begin
               flush   = 1'b1;
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               addr_d   = ADDR_W'(pack_addr(ent_q.frame, line_q[Y_W-1:0], seg_start));
               remain_d = seg_cnt;
               state_d  = StReq;
            end
         end
         StReq: begin
            if (abort) abort_pend_d = 1'b1;
            if (wr.wr_burst_data_req) state_d = StWait;
         end
         StWait: begin
            if (abort) abort_pend_d = 1'b1;
            if (wr.burst_finish) begin
               if (abort || abort_pend_q) begin
                  flush        = 1'b1;
                  done_d       = 1'b1;
                  abort_pend_d = 1'b0;
                  state_d      = StIdle;
               end else begin
                  remain_d = remain_q - burst_len;
                  addr_d   = addr_q + (ADDR_W'(burst_len) << $clog2(BYTES_PER_WORD));
                  if (remain_d != '0) begin
                     state_d = StReq;
                  end else if (!full_span && !seg_q && (we != ws)) begin
                     seg_d   = 1'b1;
                     state_d = StSeg;
                  end else if (line_q == {1'b0, ent_q.y2}) begin
                     state_d = StDone;
                  end else begin
                     line_d  = line_q + (Y_W+1)'(1);
                     seg_d   = 1'b0;
                     state_d = StSeg;
                  end
               end
            end
         end
         StDone: begin
            if (abort) flush = 1'b1;
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         ent_q        <= '0;
         line_q       <= '0;
         seg_q        <= 1'b0;
         addr_q       <= '0;
         remain_q     <= '0;
         abort_pend_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         ent_q        <= ent_d;
         line_q       <= line_d;
         seg_q        <= seg_d;
         addr_q       <= addr_d;
         remain_q     <= remain_d;
         abort_pend_q <= abort_pend_d;
         done_q       <= done_d;
         err_q        <= err_d;
         data_q       <= wr.wr_burst_data_req ? {PIX_PER_WORD{ent_q.colour}} : '0;
      end
   end

   assign wr.wr_burst_req  = (state_q == StReq);
   assign wr.wr_burst_addr = addr_q;
   assign wr.wr_burst_len  = 10'(burst_len);
   assign wr.wr_burst_data = data_q;
   assign rect_done        = done_q;
   assign rect_err         = err_q;
   assign busy             = (state_q != StIdle) || !empty;
endmodule

// File: tb/tb_rect_overlay_wr.sv
// Directed bench for rect_overlay_wr with a small memory-controller model that logs every burst.
module tb_rect_overlay_wr;
   logic        mem_clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_fill, abort;
   logic [1:0]  req_frame;
   logic [10:0] req_x1, req_x2, req_y1, req_y2;
   logic [15:0] req_colour;
   logic        rect_done, rect_err, busy;

   logic        ctrl_hold;
   logic [15:0] exp_colour;
   logic [26:0] b_addr [$];
   logic [9:0]  b_len  [$];
   int          n_done, n_err, n_both;
   int          n_total = 0;
   int          n_bad   = 0;

   rect_overlay_if #(.ADDR_W(27)) wr_if ();

   rect_overlay_wr #(
      .ADDR_W    (27),
      .MAX_BURST (128),
      .THICK     (1),
      .Q_DEPTH   (4)
   ) dut (
      .mem_clk    (mem_clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_frame  (req_frame),
      .req_x1     (req_x1),
      .req_x2     (req_x2),
      .req_y1     (req_y1),
      .req_y2     (req_y2),
      .req_colour (req_colour),
      .req_fill   (req_fill),
      .abort      (abort),
      .wr         (wr_if),
      .rect_done  (rect_done),
      .rect_err   (rect_err),
      .busy       (busy)
   );

   always #5 mem_clk = ~mem_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge mem_clk) begin
      if (rst_n) begin
         if (rect_done) n_done++;
         if (rect_err) n_err++;
         if (rect_done && rect_err) n_both++;
      end
   end

   initial begin : ctrl
      logic [9:0] len;
      wr_if.wr_burst_data_req = 1'b0;
      wr_if.burst_finish      = 1'b0;
      forever begin
         @(posedge mem_clk); #1;
         if (rst_n && wr_if.wr_burst_req && !ctrl_hold) begin
            len = wr_if.wr_burst_len;
            b_addr.push_back(wr_if.wr_burst_addr);
            b_len.push_back(len);
            @(posedge mem_clk); #1;
            for (int i = 0; i < int'(len); i++) begin
               wr_if.wr_burst_data_req = 1'b1;
               @(posedge mem_clk); #1;
               chk("data", 64'(wr_if.wr_burst_data), {4{exp_colour}});
               if (i == 0) chk("req_drop", 64'(wr_if.wr_burst_req), 64'(0));
            end
            wr_if.wr_burst_data_req = 1'b0;
            wr_if.burst_finish      = 1'b1;
            @(posedge mem_clk); #1;
            wr_if.burst_finish      = 1'b0;
            chk("data_idle", 64'(wr_if.wr_burst_data), 64'(0));
         end
      end
   end

   task automatic set_req(input logic [1:0] f, input logic [10:0] x1, input logic [10:0] x2,
                          input logic [10:0] y1, input logic [10:0] y2, input logic fl);
      req_frame  = f;
      req_x1     = x1;
      req_x2     = x2;
      req_y1     = y1;
      req_y2     = y2;
      req_colour = exp_colour;
      req_fill   = fl;
      req_valid  = 1'b1;
   endtask

   task automatic push(input logic [1:0] f, input logic [10:0] x1, input logic [10:0] x2,
                       input logic [10:0] y1, input logic [10:0] y2, input logic fl);
      set_req(f, x1, x2, y1, y2, fl);
      for (int i = 0; i < 400; i++) begin
         if (req_ready) begin
            @(posedge mem_clk); #1;
            req_valid = 1'b0;
            return;
         end
         @(posedge mem_clk); #1;
      end
      chk("push_timeout", 64'(req_ready), 64'(1));
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      for (int i = 0; i < max; i++) begin
         if (!busy) break;
         @(posedge mem_clk); #1;
      end
      chk("idle", 64'(busy), 64'(0));
      repeat (2) @(posedge mem_clk);
      #1;
   endtask

   task automatic clear();
      b_addr.delete();
      b_len.delete();
      n_done = 0;
      n_err  = 0;
      n_both = 0;
   endtask

   task automatic exp_burst(input int idx, input logic [26:0] a, input logic [9:0] l);
      if (idx < b_addr.size()) begin
         chk($sformatf("addr%0d", idx), 64'(b_addr[idx]), 64'(a));
         chk($sformatf("len%0d", idx), 64'(b_len[idx]), 64'(l));
      end else begin
         chk($sformatf("missing%0d", idx), 64'(b_addr.size()), 64'(idx + 1));
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_fill   = 1'b0;
      abort      = 1'b0;
      ctrl_hold  = 1'b0;
      exp_colour = 16'hF800;
      set_req(2'd0, 11'd0, 11'd0, 11'd0, 11'd0, 1'b0);
      req_valid  = 1'b0;
      clear();
      repeat (3) @(posedge mem_clk);
      #1;
      chk("rst_ready", 64'(req_ready), 64'(1));
      chk("rst_req", 64'(wr_if.wr_burst_req), 64'(0));
      chk("rst_addr", 64'(wr_if.wr_burst_addr), 64'(0));
      chk("rst_len", 64'(wr_if.wr_burst_len), 64'(0));
      chk("rst_data", 64'(wr_if.wr_burst_data), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'({rect_done, rect_err}), 64'(0));
      rst_n = 1'b1;
      @(posedge mem_clk); #1;

      // Outline x 8..23, lines 2..4, frame 1.
      clear();
      exp_colour = 16'hF800;
      push(2'd1, 11'd8, 11'd23, 11'd2, 11'd4, 1'b0);
      wait_idle(2000);
      chk("t1_n", 64'(b_addr.size()), 64'(4));
      exp_burst(0, 27'h0802010, 10'd4);
      exp_burst(1, 27'h0803010, 10'd1);
      exp_burst(2, 27'h0803028, 10'd1);
      exp_burst(3, 27'h0804010, 10'd4);
      chk("t1_done", 64'(n_done), 64'(1));
      chk("t1_err", 64'(n_err), 64'(0));

      // 256-word line splits into two MAX_BURST bursts.
      clear();
      exp_colour = 16'h001F;
      push(2'd0, 11'd0, 11'd1023, 11'd0, 11'd0, 1'b0);
      wait_idle(3000);
      chk("t2_n", 64'(b_addr.size()), 64'(2));
      exp_burst(0, 27'h0000000, 10'd128);
      exp_burst(1, 27'h0000400, 10'd128);
      chk("t2_done", 64'(n_done), 64'(1));

      // Bottom line at the largest line number.
      clear();
      exp_colour = 16'h07E0;
      push(2'd0, 11'd0, 11'd0, 11'd2046, 11'd2047, 1'b0);
      wait_idle(2000);
      chk("t3_n", 64'(b_addr.size()), 64'(2));
      exp_burst(0, 27'h07FE000, 10'd1);
      exp_burst(1, 27'h07FF000, 10'd1);
      chk("t3_done", 64'(n_done), 64'(1));

      // Malformed request.
      clear();
      push(2'd0, 11'd10, 11'd3, 11'd0, 11'd0, 1'b0);
      wait_idle(200);
      chk("t4_n", 64'(b_addr.size()), 64'(0));
      chk("t4_err", 64'(n_err), 64'(1));
      chk("t4_both", 64'(n_both), 64'(1));
      chk("t4_done", 64'(n_done), 64'(1));

      // Queue full: one rectangle stalled in REQ, four queued, fifth retried.
      clear();
      exp_colour = 16'h1234;
      ctrl_hold  = 1'b1;
      push(2'd0, 11'd0, 11'd0, 11'd10, 11'd10, 1'b0);
      repeat (4) @(posedge mem_clk);
      #1;
      for (int k = 1; k <= 4; k++) push(2'd0, 11'd0, 11'd0, 11'(k), 11'(k), 1'b0);
      set_req(2'd0, 11'd0, 11'd0, 11'd5, 11'd5, 1'b0);
      chk("t5_full", 64'(req_ready), 64'(0));
      repeat (3) @(posedge mem_clk);
      #1;
      chk("t5_full2", 64'(req_ready), 64'(0));
      chk("t5_busy", 64'(busy), 64'(1));
      ctrl_hold = 1'b0;
      push(2'd0, 11'd0, 11'd0, 11'd5, 11'd5, 1'b0);
      wait_idle(3000);
      chk("t5_n", 64'(b_addr.size()), 64'(6));
      exp_burst(0, 27'h000A000, 10'd1);
      for (int k = 1; k <= 5; k++) exp_burst(k, 27'(k * 4096), 10'd1);
      chk("t5_done", 64'(n_done), 64'(6));

      // Abort during the second burst with two requests queued.
      clear();
      exp_colour = 16'hABCD;
      push(2'd0, 11'd0, 11'd3, 11'd0, 11'd2, 1'b0);
      push(2'd0, 11'd0, 11'd3, 11'd5, 11'd5, 1'b0);
      push(2'd0, 11'd0, 11'd3, 11'd6, 11'd6, 1'b0);
      for (int i = 0; i < 500; i++) begin
         if (b_addr.size() >= 2) break;
         @(posedge mem_clk); #2;
      end
      abort = 1'b1;
      @(posedge mem_clk); #1;
      abort = 1'b0;
      wait_idle(500);
      repeat (20) @(posedge mem_clk);
      #1;
      chk("t6_n", 64'(b_addr.size()), 64'(2));
      exp_burst(0, 27'h0000000, 10'd1);
      exp_burst(1, 27'h0001000, 10'd1);
      chk("t6_done", 64'(n_done), 64'(1));
      chk("t6_busy", 64'(busy), 64'(0));

      // Single-word-wide rectangle with fill requested: same bursts with or without fill support.
      clear();
      exp_colour = 16'h5A5A;
      push(2'd2, 11'd4, 11'd4, 11'd5, 11'd7, 1'b1);
      wait_idle(2000);
      chk("t7_n", 64'(b_addr.size()), 64'(3));
      exp_burst(0, 27'h1005008, 10'd1);
      exp_burst(1, 27'h1006008, 10'd1);
      exp_burst(2, 27'h1007008, 10'd1);
      chk("t7_done", 64'(n_done), 64'(1));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
